// File: rtl/color_sequencer.sv
// Breather colour source: steps rgb_o on each breath cycle, button selects mode.
// Define COLOR_SEQ_LFSR_EN to make mode 2 pseudo-random instead of a 1..7 walk.
module color_sequencer #(
  parameter int          DEBOUNCE_CYCLES = 312500,
  parameter logic [2:0]  FIXED_COLOR     = 3'b111
) (
  input  logic       clk_div_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       cycle_i,
  output logic [2:0] rgb_o,
  output logic [1:0] mode_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    M_FIXED = 2'd0,
    M_RGB   = 2'd1,
    M_WALK  = 2'd2,
    M_OFF   = 2'd3
  } mode_e;

  logic          btn_s1_q, btn_s2_q;
  logic          cyc_s1_q, cyc_s2_q, cyc_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  mode_e         mode_q, mode_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          cyc_ev, press;

`ifdef COLOR_SEQ_LFSR_EN
  logic [7:0]    lfsr_q, lfsr_d;
`endif

  always_comb begin
    cyc_ev = cyc_s2_q & ~cyc_prev_q;
    cnt_d  = '0;
    deb_d  = deb_q;
    press  = 1'b0;
    if (btn_s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = ~deb_q;
        press = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    mode_d = mode_q;
    idx_d  = idx_q;
    if (press) begin
      mode_d = mode_e'(mode_q + 2'd1);
      idx_d  = (mode_d == M_WALK) ? 3'd1 : 3'd0;
    end else if (cyc_ev) begin
      if (mode_q == M_RGB)
        idx_d = (idx_q == 3'd2) ? 3'd0 : idx_q + 3'd1;
      else if (mode_q == M_WALK)
        idx_d = (idx_q == 3'd7) ? 3'd1 : idx_q + 3'd1;
    end

`ifdef COLOR_SEQ_LFSR_EN
    lfsr_d = lfsr_q;
    if (press && mode_d == M_WALK)
      lfsr_d = 8'hA5;
    else if (!press && cyc_ev && mode_q == M_WALK)
      lfsr_d = {lfsr_q[6:0],
                lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

    // Decode from next-state so the colour changes with mode_o.
    rgb_d = FIXED_COLOR;
    unique case (mode_d)
      M_FIXED: rgb_d = FIXED_COLOR;
      M_RGB: begin
        unique case (idx_d)
          3'd0:    rgb_d = 3'b100;
          3'd1:    rgb_d = 3'b010;
          default: rgb_d = 3'b001;
        endcase
      end
`ifdef COLOR_SEQ_LFSR_EN
      M_WALK:  rgb_d = (lfsr_d[2:0] == 3'b000) ? 3'b111 : lfsr_d[2:0];
`else
      M_WALK:  rgb_d = idx_d;
`endif
      M_OFF:   rgb_d = 3'b000;
      default: rgb_d = FIXED_COLOR;
    endcase
  end

  always_ff @(posedge clk_div_i) begin
    if (rst_i) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      cyc_s1_q   <= 1'b0;
      cyc_s2_q   <= 1'b0;
      cyc_prev_q <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      mode_q     <= M_FIXED;
      idx_q      <= 3'd0;
      rgb_q      <= FIXED_COLOR;
`ifdef COLOR_SEQ_LFSR_EN
      lfsr_q     <= 8'hA5;
`endif
    end else begin
      btn_s1_q   <= btn_i;
      btn_s2_q   <= btn_s1_q;
      cyc_s1_q   <= cycle_i;
      cyc_s2_q   <= cyc_s1_q;
      cyc_prev_q <= cyc_s2_q;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      rgb_q      <= rgb_d;
`ifdef COLOR_SEQ_LFSR_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign rgb_o  = rgb_q;
  assign mode_o = mode_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Bench for color_sequencer: directed literal checks plus a per-cycle
// comparison against a sample-history reference model under random stimulus.
module tb_color_sequencer;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       btn_i = 1'b0;
  logic       cycle_i = 1'b0;
  logic [2:0] rgb_o;
  logic [1:0] mode_o;

  int pass_cnt = 0;
  int tot_cnt = 0;
  bit chk_en = 1'b0;

  color_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .FIXED_COLOR(3'b111)
  ) dut (
    .clk_div_i(clk),
    .rst_i(rst_i),
    .btn_i(btn_i),
    .cycle_i(cycle_i),
    .rgb_o(rgb_o),
    .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  // Reference model state: inputs as sampled at the last few edges,
  // debounce run length, mode and number of steps taken in this mode.
  bit bh[2];
  bit ch[3];
  bit m_lvl;
  int m_run;
  int m_mode;
  int m_pos;

  function automatic logic [2:0] lfsr_rgb(input int steps);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < steps; i++)
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return (v[2:0] == 3'b000) ? 3'b111 : v[2:0];
  endfunction

  function automatic logic [2:0] exp_rgb(input int md, input int pos);
    logic [2:0] one_hot;
    case (md)
      0: return 3'b111;
      1: begin
        one_hot = 3'b100;
        return one_hot >> (pos % 3);
      end
`ifdef COLOR_SEQ_LFSR_EN
      2: return lfsr_rgb(pos);
`else
      2: return 3'((pos % 7) + 1);
`endif
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_step();
    bit b2, ev, press;
    if (rst_i) begin
      bh = '{0, 0};
      ch = '{0, 0, 0};
      m_lvl = 0;
      m_run = 0;
      m_mode = 0;
      m_pos = 0;
    end else begin
      b2 = bh[1];
      ev = ch[1] && !ch[2];
      press = 0;
      if (b2 != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = !m_lvl;
          m_run = 0;
          press = m_lvl;
        end
      end else begin
        m_run = 0;
      end
      if (press) begin
        m_mode = (m_mode + 1) % 4;
        m_pos = 0;
      end else if (ev && (m_mode == 1 || m_mode == 2)) begin
        m_pos++;
      end
      bh[1] = bh[0];
      bh[0] = btn_i;
      ch[2] = ch[1];
      ch[1] = ch[0];
      ch[0] = cycle_i;
    end
  endtask

  task automatic chk(input string name, input logic [4:0] act,
                     input logic [4:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got mode/rgb %b, want %b", name, act, exp);
  endtask

  // Inputs only change 1ns after a falling edge, so at the falling edge
  // they still hold the values sampled at the preceding rising edge.
  initial begin
    forever begin
      @(negedge clk);
      model_step();
      if (chk_en)
        chk("model", {mode_o, rgb_o},
            {2'(m_mode), exp_rgb(m_mode, m_pos)});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    cycle_i = 1'b1;
    tick(3);
    cycle_i = 1'b0;
    tick(3);
  endtask

  logic [2:0] exp_seq[];

  initial begin
    rst_i = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    rst_i = 1'b0;
    chk("reset", {mode_o, rgb_o}, {2'd0, 3'b111});
    repeat (5) pulse();
    chk("fixed_ignores_cycle", {mode_o, rgb_o}, {2'd0, 3'b111});

    btn_i = 1'b1;
    tick(3);
    btn_i = 1'b0;
    tick(10);
    chk("glitch", {mode_o, rgb_o}, {2'd0, 3'b111});

    btn_i = 1'b1;
    tick(10);
    chk("press_mode1", {mode_o, rgb_o}, {2'd1, 3'b100});
    btn_i = 1'b0;
    tick(10);
    chk("release", {mode_o, rgb_o}, {2'd1, 3'b100});

    exp_seq = '{3'b010, 3'b001, 3'b100, 3'b010};
    foreach (exp_seq[i]) begin
      cycle_i = 1'b1;
      tick(2);
      chk("rgb_not_yet", {mode_o, rgb_o},
          {2'd1, (i == 0) ? 3'b100 : exp_seq[i-1]});
      tick(1);
      chk("rgb_step", {mode_o, rgb_o}, {2'd1, exp_seq[i]});
      cycle_i = 1'b0;
      tick(3);
    end

    // Button up three samples before the cycle rise: press lands on cyc_ev.
    btn_i = 1'b1;
    tick(3);
    cycle_i = 1'b1;
    tick(3);
`ifdef COLOR_SEQ_LFSR_EN
    chk("collision", {mode_o, rgb_o}, {2'd2, 3'b101});
`else
    chk("collision", {mode_o, rgb_o}, {2'd2, 3'b001});
`endif
    cycle_i = 1'b0;
    btn_i = 1'b0;
    tick(10);

`ifdef COLOR_SEQ_LFSR_EN
    pulse();
    chk("lfsr_step", {mode_o, rgb_o}, {2'd2, 3'b010});
`else
    exp_seq = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
    foreach (exp_seq[i]) begin
      pulse();
      chk("walk", {mode_o, rgb_o}, {2'd2, exp_seq[i]});
    end
`endif

    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    chk("mid_reset", {mode_o, rgb_o}, {2'd0, 3'b111});

    repeat (4000) begin
      if ($urandom_range(5) == 0) btn_i = ~btn_i;
      if ($urandom_range(3) == 0) cycle_i = ~cycle_i;
      rst_i = ($urandom_range(599) == 0);
      tick(1);
    end
    rst_i = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
